// File: rtl/reduce_tree_pipe_pkg.sv
// Shared op encoding and elaboration-time helpers for the pipelined reduction tree.
package reduce_tree_pipe_pkg;

   typedef enum logic [1:0] {
      OP_AND = 2'd0,
      OP_OR  = 2'd1,
      OP_XOR = 2'd2
   } op_e;

   // Reserved encoding 3 behaves as AND, so its identity is 1 as well.
   function automatic logic identity(input logic [1:0] op);
      return !(op == OP_OR || op == OP_XOR);
   endfunction

   function automatic logic combine(input logic [1:0] op, input logic a, input logic b);
      case (op)
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return a & b;
      endcase
   endfunction

   function automatic int clog_base(input int n, input int base);
      int r = 0;
      int p = 1;
      while (p < n) begin
         p = p * base;
         r++;
      end
      return r;
   endfunction

   function automatic int pow_int(input int b, input int e);
      int p = 1;
      for (int i = 0; i < e; i++) p = p * b;
      return p;
   endfunction

   function automatic int nodes_at_level(input int n, input int fanin, input int lvl);
      int d = pow_int(fanin, lvl);
      return (n + d - 1) / d;
   endfunction

endpackage

// File: rtl/reduce_tree_pipe_if.sv
// Input and output valid/ready channels of the reduction tree.
interface reduce_tree_pipe_if #(
   parameter int INPUT_SIZE = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [INPUT_SIZE-1:0] in_data;
   logic [1:0]            in_op;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_data;
   logic [1:0]            out_op;

   modport master (
      output in_valid, in_data, in_op, out_ready,
      input  in_ready, out_valid, out_data, out_op
   );

   modport slave (
      input  in_valid, in_data, in_op, out_ready,
      output in_ready, out_valid, out_data, out_op
   );
endinterface

// File: rtl/reduce_tree_pipe_stage.sv
// One tree level: FANIN-input nodes feeding a valid/op/partial register with
// bubble-collapsing advance.
module reduce_tree_pipe_stage
   import reduce_tree_pipe_pkg::*;
#(
   parameter int IN_W  = 2,
   parameter int FANIN = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              i_valid,
   input  logic [1:0]                        i_op,
   input  logic [IN_W-1:0]                   i_data,
   output logic                              o_ready,
   output logic                              o_valid,
   output logic [1:0]                        o_op,
   output logic [(IN_W+FANIN-1)/FANIN-1:0]   o_data,
   input  logic                              i_next_ready
);
   localparam int OUT_W = (IN_W + FANIN - 1) / FANIN;
   localparam int PAD_W = OUT_W * FANIN;

   logic [PAD_W-1:0] w_pad;
   logic [OUT_W-1:0] w_node;
   logic             w_acc;
   logic             r_valid;
   logic [1:0]       r_op;
   logic [OUT_W-1:0] r_data;

   // A ragged last node sees the op identity on its missing inputs.
   always_comb begin
      w_pad             = {PAD_W{identity(i_op)}};
      w_pad[IN_W-1:0]   = i_data;
      w_node            = '0;
      w_acc             = 1'b0;
      for (int j = 0; j < OUT_W; j++) begin
         w_acc = w_pad[j*FANIN];
         for (int b = 1; b < FANIN; b++) w_acc = combine(i_op, w_acc, w_pad[j*FANIN+b]);
         w_node[j] = w_acc;
      end
   end

   assign o_ready = !r_valid || i_next_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_op    <= 2'd0;
         r_data  <= '0;
      end else if (o_ready) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_op   <= i_op;
            r_data <= w_node;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_op    = r_op;
   assign o_data  = r_data;
endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined N-input AND/OR/XOR reduction tree with valid/ready handshake and
// an output-toggle counter.
module reduce_tree_pipe
   import reduce_tree_pipe_pkg::*;
#(
   parameter int INPUT_SIZE = 8,
   parameter int FANIN      = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   reduce_tree_pipe_if.slave bus,
   input  logic             i_toggle_clr,
   output logic [CNT_W-1:0] o_toggle_cnt
);
   localparam int LEVELS = clog_base(INPUT_SIZE, FANIN);
   localparam int LEAF_W = pow_int(FANIN, LEVELS);

   logic [LEAF_W-1:0] w_leaf;
   logic [LEAF_W-1:0] w_lvl_data  [LEVELS+1];
   logic              w_lvl_valid [LEVELS+1];
   logic [1:0]        w_lvl_op    [LEVELS+1];
   logic              w_lvl_ready [LEVELS+1];
   logic              w_out_valid;
   logic              w_out_data;
   logic              w_hs;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_last;

   // Pad to a full FANIN**LEVELS tree so every level divides evenly.
   always_comb begin
      w_leaf                   = {LEAF_W{identity(bus.in_op)}};
      w_leaf[INPUT_SIZE-1:0]   = bus.in_data;
   end

   assign w_lvl_data[0]       = w_leaf;
   assign w_lvl_valid[0]      = bus.in_valid;
   assign w_lvl_op[0]         = bus.in_op;
   assign w_lvl_ready[LEVELS] = bus.out_ready;
   assign bus.in_ready        = w_lvl_ready[0];

   for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int IN_W  = nodes_at_level(LEAF_W, FANIN, k);
      localparam int OUT_W = nodes_at_level(LEAF_W, FANIN, k + 1);
      logic [OUT_W-1:0] w_out;

      reduce_tree_pipe_stage #(
         .IN_W  (IN_W),
         .FANIN (FANIN)
      ) u_stage (
         .clk          (clk),
         .rst_n        (rst_n),
         .i_valid      (w_lvl_valid[k]),
         .i_op         (w_lvl_op[k]),
         .i_data       (w_lvl_data[k][IN_W-1:0]),
         .o_ready      (w_lvl_ready[k]),
         .o_valid      (w_lvl_valid[k+1]),
         .o_op         (w_lvl_op[k+1]),
         .o_data       (w_out),
         .i_next_ready (w_lvl_ready[k+1])
      );

      assign w_lvl_data[k+1] = LEAF_W'(w_out);
   end

   assign w_out_valid   = w_lvl_valid[LEVELS];
   assign w_out_data    = w_lvl_data[LEVELS][0];
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_out_data;
   assign bus.out_op    = w_lvl_op[LEVELS];

   assign w_hs = w_out_valid && bus.out_ready;

   // Clear wins over a coincident toggle; the last-result tracker still updates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_last <= 1'b0;
      end else begin
         if (w_hs) r_last <= w_out_data;
         if (i_toggle_clr) r_cnt <= '0;
         else if (w_hs && (w_out_data != r_last) && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_toggle_cnt = r_cnt;
endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Directed bench for reduce_tree_pipe: 8/2 default, 5-input padded tree, and a
// 2-bit toggle counter instance sharing one clock and reset.
module tb_reduce_tree_pipe;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clr_a = 1'b0;
   logic        clr_b = 1'b0;
   logic        clr_c = 1'b0;
   logic [15:0] cnt_a;
   logic [15:0] cnt_b;
   logic [1:0]  cnt_c;
   int          n_chk = 0;
   int          n_err = 0;

   reduce_tree_pipe_if #(.INPUT_SIZE(8)) a_if ();
   reduce_tree_pipe_if #(.INPUT_SIZE(5)) b_if ();
   reduce_tree_pipe_if #(.INPUT_SIZE(8)) c_if ();

   reduce_tree_pipe #(.INPUT_SIZE(8), .FANIN(2), .CNT_W(16)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .bus(a_if), .i_toggle_clr(clr_a), .o_toggle_cnt(cnt_a));
   reduce_tree_pipe #(.INPUT_SIZE(5), .FANIN(2), .CNT_W(16)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .bus(b_if), .i_toggle_clr(clr_b), .o_toggle_cnt(cnt_b));
   reduce_tree_pipe #(.INPUT_SIZE(8), .FANIN(2), .CNT_W(2)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .bus(c_if), .i_toggle_clr(clr_c), .o_toggle_cnt(cnt_c));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   logic [7:0] t2_d [5] = '{8'hFF, 8'h7F, 8'h00, 8'h01, 8'h03};
   logic [1:0] t2_o [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
   logic       t2_e [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

   logic [7:0] t3_d [7] = '{8'hFF, 8'h80, 8'h00, 8'h07, 8'hFF, 8'hFE, 8'h81};
   logic [1:0] t3_o [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
   logic       t3_e [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   logic [4:0] t4_d [5] = '{5'h1F, 5'h00, 5'h1F, 5'h0F, 5'h10};
   logic [1:0] t4_o [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
   logic       t4_e [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1);
   end

   initial begin
      int lat, got, first, lastc, sent, acc_stall, w, vcount;
      a_if.in_valid = 0; a_if.in_data = '0; a_if.in_op = '0; a_if.out_ready = 0;
      b_if.in_valid = 0; b_if.in_data = '0; b_if.in_op = '0; b_if.out_ready = 0;
      c_if.in_valid = 0; c_if.in_data = '0; c_if.in_op = '0; c_if.out_ready = 0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", a_if.out_valid, 1'b0);
      chk("rst_out_data", a_if.out_data, 1'b0);
      chk("rst_out_op", a_if.out_op, 2'd0);
      chk("rst_toggle_cnt", cnt_a, 16'd0);
      chk("rst_in_ready", a_if.in_ready, 1'b1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single transaction latency
      a_if.out_ready = 1; a_if.in_valid = 1; a_if.in_data = 8'hFF; a_if.in_op = 2'd0;
      #1 chk("t1_in_ready", a_if.in_ready, 1'b1);
      @(posedge clk); #1;
      a_if.in_valid = 0;
      lat = 1;
      while (!a_if.out_valid && lat < 10) begin
         @(posedge clk); #1; lat++;
      end
      chk("t1_latency", lat, 3);
      chk("t1_data", a_if.out_data, 1'b1);
      chk("t1_op", a_if.out_op, 2'd0);
      @(posedge clk); #1;
      chk("t1_toggle", cnt_a, 16'd1);
      chk("t1_drained", a_if.out_valid, 1'b0);

      // back-to-back mixed ops
      got = 0; first = -1; lastc = -1;
      for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
         if (cyc < 5) begin
            a_if.in_valid = 1; a_if.in_data = t2_d[cyc]; a_if.in_op = t2_o[cyc];
         end else a_if.in_valid = 0;
         #1;
         if (cyc < 5) chk("t2_in_ready", a_if.in_ready, 1'b1);
         if (a_if.out_valid) begin
            chk($sformatf("t2_data%0d", got), a_if.out_data, t2_e[got]);
            chk($sformatf("t2_op%0d", got), a_if.out_op, t2_o[got]);
            if (got == 0) first = cyc;
            lastc = cyc;
            got++;
         end
         @(posedge clk); #1;
      end
      a_if.in_valid = 0;
      chk("t2_count", got, 5);
      chk("t2_first", first, 3);
      chk("t2_span", lastc - first, 4);
      chk("t2_toggle", cnt_a, 16'd4);

      // output stall with continuous input stream
      sent = 0; got = 0; acc_stall = 0;
      for (int cyc = 0; cyc < 40 && got < 7; cyc++) begin
         a_if.out_ready = (cyc >= 5);
         if (sent < 7) begin
            a_if.in_valid = 1; a_if.in_data = t3_d[sent]; a_if.in_op = t3_o[sent];
         end else a_if.in_valid = 0;
         #1;
         if (cyc < 5 && a_if.in_valid && a_if.in_ready) acc_stall++;
         if (cyc == 3 || cyc == 4) begin
            chk("t3_full_in_ready", a_if.in_ready, 1'b0);
            chk("t3_hold_valid", a_if.out_valid, 1'b1);
            chk("t3_hold_data", a_if.out_data, 1'b1);
            chk("t3_hold_op", a_if.out_op, 2'd0);
         end
         if (a_if.in_valid && a_if.in_ready) sent++;
         if (a_if.out_valid && a_if.out_ready) begin
            chk($sformatf("t3_data%0d", got), a_if.out_data, t3_e[got]);
            chk($sformatf("t3_op%0d", got), a_if.out_op, t3_o[got]);
            got++;
         end
         @(posedge clk); #1;
      end
      a_if.in_valid = 0;
      chk("t3_stall_accepts", acc_stall, 3);
      chk("t3_sent", sent, 7);
      chk("t3_got", got, 7);
      repeat (3) @(posedge clk);
      #1 chk("t3_no_extra", a_if.out_valid, 1'b0);
      chk("t3_toggle", cnt_a, 16'd8);

      // 5-input tree with identity padding
      got = 0; first = -1;
      b_if.out_ready = 1;
      for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
         if (cyc < 5) begin
            b_if.in_valid = 1; b_if.in_data = t4_d[cyc]; b_if.in_op = t4_o[cyc];
         end else b_if.in_valid = 0;
         #1;
         if (b_if.out_valid) begin
            chk($sformatf("t4_data%0d", got), b_if.out_data, t4_e[got]);
            if (got == 0) first = cyc;
            got++;
         end
         @(posedge clk); #1;
      end
      b_if.in_valid = 0;
      chk("t4_count", got, 5);
      chk("t4_latency", first, 3);

      // 2-bit counter saturation, then clear coincident with a toggle
      got = 0;
      c_if.out_ready = 1;
      for (int cyc = 0; cyc < 20 && got < 6; cyc++) begin
         if (cyc < 6) begin
            c_if.in_valid = 1; c_if.in_data = (cyc % 2 == 0) ? 8'hFF : 8'h00; c_if.in_op = 2'd0;
         end else c_if.in_valid = 0;
         #1;
         if (c_if.out_valid) begin
            chk($sformatf("t6_data%0d", got), c_if.out_data, (got % 2 == 0) ? 1'b1 : 1'b0);
            got++;
         end
         @(posedge clk); #1;
      end
      c_if.in_valid = 0;
      chk("t6_count", got, 6);
      chk("t6_saturate", cnt_c, 2'd3);

      c_if.in_valid = 1; c_if.in_data = 8'hFF; c_if.in_op = 2'd0;
      @(posedge clk); #1;
      c_if.in_valid = 0;
      w = 0;
      while (!c_if.out_valid && w < 10) begin
         @(posedge clk); #1; w++;
      end
      chk("t6_clr_wait", c_if.out_valid, 1'b1);
      chk("t6_clr_data", c_if.out_data, 1'b1);
      clr_c = 1;
      @(posedge clk); #1;
      clr_c = 0;
      chk("t6_clr_wins", cnt_c, 2'd0);

      c_if.in_valid = 1; c_if.in_data = 8'h00; c_if.in_op = 2'd0;
      @(posedge clk); #1;
      c_if.in_valid = 0;
      w = 0;
      while (!c_if.out_valid && w < 10) begin
         @(posedge clk); #1; w++;
      end
      chk("t6_after_wait", c_if.out_valid, 1'b1);
      @(posedge clk); #1;
      chk("t6_after_clr", cnt_c, 2'd1);

      // asynchronous reset mid-stream
      a_if.out_ready = 1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         a_if.in_valid = 1; a_if.in_data = 8'hFF; a_if.in_op = 2'd0;
         @(posedge clk); #1;
      end
      a_if.in_valid = 0;
      chk("t5_pre_valid", a_if.out_valid, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_async_valid", a_if.out_valid, 1'b0);
      chk("t5_async_data", a_if.out_data, 1'b0);
      chk("t5_async_cnt", cnt_a, 16'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      vcount = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (a_if.out_valid) vcount++;
         @(posedge clk); #1;
      end
      chk("t5_no_stale", vcount, 0);
      chk("t5_cnt", cnt_a, 16'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
